// File: rtl/pwm_capture_pkg.sv
// Shared types and default parameters for the PWM input capture block.
package pwm_capture_pkg;

  // Capture FSM: wait for enable, wait for first rise, then alternate high/low phases.
  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } cap_state_e;

  localparam int unsigned DefCntWidth  = 32;
  localparam int unsigned DefPscrWidth = 20;
  localparam int unsigned DefSyncStage = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module cdc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_cap_tick_gen.sv
// Prescaler: emits a tick every pscr_i+1 clocks, phase-aligned to the last restart.
module pwm_cap_tick_gen
  import pwm_capture_pkg::*;
#(
  parameter int unsigned PSCR_WIDTH = DefPscrWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  restart_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  output logic                  tick_o
);

  localparam logic [PSCR_WIDTH-1:0] PreOne = 1;

  logic [PSCR_WIDTH-1:0] pre_q, pre_d;
  logic                  wrap;

  // >= rather than == so a live decrease of pscr_i cannot strand the counter above it.
  always_comb begin
    wrap   = (pre_q >= pscr_i);
    tick_o = wrap & ~restart_i;
    if (restart_i || wrap) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PreOne;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_capture_core.sv
// Single-channel PWM capture: measures period and high time in prescaled ticks and
// publishes each result over a valid/ready pair.
module pwm_capture_core
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = DefCntWidth,
  parameter int unsigned PSCR_WIDTH = DefPscrWidth,
  parameter int unsigned SYNC_STAGE = DefSyncStage
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  pol_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic                  ie_i,
  input  logic                  pwm_i,
  output logic                  meas_valid_o,
  input  logic                  meas_ready_i,
  output logic [CNT_WIDTH-1:0]  period_o,
  output logic [CNT_WIDTH-1:0]  high_o,
  output logic                  ovf_o,
  output logic                  miss_o,
  output logic                  level_o,
  output logic                  irq_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic pwm_sync, lvl_s, lvl_q, rise, fall, tick;
  logic sat, publish;

  cap_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] high_cap_q, high_cap_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_out_q, high_out_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 miss_q, miss_d;

  cdc_sync #(
    .STAGES (SYNC_STAGE)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pwm_i),
    .q_o     (pwm_sync)
  );

  assign lvl_s = pwm_sync ^ pol_i;
  assign rise  = lvl_s & ~lvl_q;
  assign fall  = ~lvl_s & lvl_q;

  // Restart only on rise so the period count stays ceil(clocks/(pscr+1)) across the fall.
  pwm_cap_tick_gen #(
    .PSCR_WIDTH (PSCR_WIDTH)
  ) u_tick_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .restart_i (rise),
    .pscr_i    (pscr_i),
    .tick_o    (tick)
  );

  // Next-state for counter, FSM, sticky flags and the output holding register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    period_d   = period_q;
    high_out_d = high_out_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    miss_d     = miss_q;
    publish    = 1'b0;
    sat        = tick && (cnt_q == CntMax);

    if (clr_i) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CntOne;
    end else if (tick && !sat) begin
      cnt_d = cnt_q + CntOne;
    end

    if (valid_q && meas_ready_i) begin
      valid_d = 1'b0;
    end

    if (clr_i) begin
      ovf_d  = 1'b0;
      miss_d = 1'b0;
    end

    if (!en_i) begin
      state_d = StIdle;
    end else if (clr_i) begin
      state_d = StArm;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm:  if (rise) state_d = StHigh;
        StHigh: begin
          if (sat) begin
            ovf_d   = 1'b1;
            state_d = StArm;
          end else if (fall) begin
            high_cap_d = cnt_q;
            state_d    = StLow;
          end
        end
        StLow: begin
          if (sat) begin
            ovf_d   = 1'b1;
            state_d = StArm;
          end else if (rise) begin
            publish = 1'b1;
            state_d = StHigh;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A result arriving while the previous one is still stalled is dropped.
    if (publish) begin
      if (valid_q && !meas_ready_i) begin
        miss_d = 1'b1;
      end else begin
        period_d   = cnt_q;
        high_out_d = high_cap_q;
        valid_d    = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      lvl_q      <= 1'b0;
      cnt_q      <= '0;
      high_cap_q <= '0;
      period_q   <= '0;
      high_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_s;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
      period_q   <= period_d;
      high_out_q <= high_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      miss_q     <= miss_d;
    end
  end

  assign meas_valid_o = valid_q;
  assign period_o     = period_q;
  assign high_o       = high_out_q;
  assign ovf_o        = ovf_q;
  assign miss_o       = miss_q;
  assign level_o      = lvl_q;
  assign irq_o        = ie_i & (valid_q | ovf_q | miss_q);

endmodule

// File: tb/tb_pwm_capture_core.sv
// Directed bench for pwm_capture_core with a scoreboard of expected measurements.
module tb_pwm_capture_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, pol = 1'b0, ie = 1'b0, pwm = 1'b0, ready = 1'b0;
  logic [19:0] pscr = '0;
  logic        valid, ovf, miss, level, irq;
  logic [7:0]  period, high;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] h;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pwm_capture_core #(
    .CNT_WIDTH  (8),
    .PSCR_WIDTH (20),
    .SYNC_STAGE (2)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .clr_i        (clr),
    .pol_i        (pol),
    .pscr_i       (pscr),
    .ie_i         (ie),
    .pwm_i        (pwm),
    .meas_valid_o (valid),
    .meas_ready_i (ready),
    .period_o     (period),
    .high_o       (high),
    .ovf_o        (ovf),
    .miss_o       (miss),
    .level_o      (level),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] h);
    exp_t e;
    e.p = p;
    e.h = h;
    sb.push_back(e);
  endtask

  // First period only arms the FSM; each later rise completes one expected result.
  task automatic pwm_seq(input int hi, input int lo, input int nfull,
                         input logic [7:0] p, input logic [7:0] h);
    pwm = 1'b1; cyc(hi); pwm = 1'b0; cyc(lo);
    for (int i = 0; i < nfull; i++) begin
      push(p, h);
      pwm = 1'b1; cyc(hi); pwm = 1'b0; cyc(lo);
    end
  endtask

  // Pop and compare on every accepted transfer.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_publish: observed period %0d high %0d expected none",
               period, high);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("period", {24'd0, period}, {24'd0, e.p});
        chk("high", {24'd0, high}, {24'd0, e.h});
      end
    end
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_period", {24'd0, period}, 0);
    chk("rst_high", {24'd0, high}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_miss", {31'd0, miss}, 0);
    chk("rst_level", {31'd0, level}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    rst_n = 1'b1;

    // pscr=0, 3 high / 5 low
    ready = 1'b1; en = 1'b1; cyc(5);
    pwm_seq(3, 5, 4, 8'd8, 8'd3);
    cyc(5); en = 1'b0; cyc(5);
    chk("sb_drain_a", sb.size(), 0);

    // pscr=3 then pscr=2, 10 high / 30 low
    pscr = 20'd3; en = 1'b1; cyc(5);
    pwm_seq(10, 30, 2, 8'd10, 8'd3);
    en = 1'b0; cyc(5);
    pscr = 20'd2; en = 1'b1; cyc(5);
    pwm_seq(10, 30, 2, 8'd14, 8'd4);
    en = 1'b0; cyc(5);
    chk("sb_drain_b", sb.size(), 0);

    // Inverted polarity: low time of pwm is measured as high
    pscr = '0; pol = 1'b1; cyc(5);
    chk("pol_level", {31'd0, level}, 1);
    en = 1'b1; cyc(3);
    pwm_seq(3, 5, 3, 8'd8, 8'd5);
    cyc(5); en = 1'b0; pol = 1'b0; cyc(5);
    chk("sb_drain_c", sb.size(), 0);

    // Backpressure: A held, B dropped
    ready = 1'b0; ie = 1'b1; en = 1'b1; cyc(5);
    pwm = 1'b1; cyc(3); pwm = 1'b0; cyc(5);
    push(8'd8, 8'd3);
    pwm = 1'b1; cyc(4); pwm = 1'b0; cyc(6);
    pwm = 1'b1; cyc(5);
    chk("bp_valid", {31'd0, valid}, 1);
    chk("bp_period", {24'd0, period}, 8);
    chk("bp_high", {24'd0, high}, 3);
    chk("bp_miss", {31'd0, miss}, 1);
    chk("bp_irq", {31'd0, irq}, 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_miss", {31'd0, miss}, 0);
    chk("clr_keeps_valid", {31'd0, valid}, 1);
    chk("clr_keeps_period", {24'd0, period}, 8);
    cyc(3); pwm = 1'b0; cyc(4);
    pwm = 1'b1; cyc(2); pwm = 1'b0; cyc(4);
    push(8'd6, 8'd2);
    // Ready high exactly in the capture cycle: old goes out, new loads, valid stays up
    pwm = 1'b1; cyc(2);
    ready = 1'b1; cyc(1); ready = 1'b0;
    chk("swap_valid", {31'd0, valid}, 1);
    chk("swap_period", {24'd0, period}, 6);
    chk("swap_high", {24'd0, high}, 2);
    chk("swap_miss", {31'd0, miss}, 0);
    ready = 1'b1; cyc(2);
    chk("swap_drained", {31'd0, valid}, 0);

    // Saturation with pwm stuck high
    en = 1'b0; pwm = 1'b0; cyc(5);
    clr = 1'b1; cyc(1); clr = 1'b0;
    en = 1'b1; cyc(3);
    pwm = 1'b1; cyc(250);
    chk("ovf_early", {31'd0, ovf}, 0);
    cyc(20);
    chk("ovf_set", {31'd0, ovf}, 1);
    chk("ovf_level", {31'd0, level}, 1);
    chk("ovf_irq", {31'd0, irq}, 1);
    chk("ovf_no_valid", {31'd0, valid}, 0);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("ovf_clr", {31'd0, ovf}, 0);
    chk("ovf_clr_irq", {31'd0, irq}, 0);

    // Enable dropped mid-HIGH: need a full new rise-fall-rise
    en = 1'b0; pwm = 1'b0; cyc(5);
    en = 1'b1; cyc(3);
    pwm = 1'b1; cyc(6);
    en = 1'b0; cyc(2); en = 1'b1; cyc(2);
    pwm = 1'b0; cyc(5);
    pwm = 1'b1; cyc(3);
    chk("en_no_publish", {31'd0, valid}, 0);
    pwm = 1'b0; cyc(5);
    push(8'd8, 8'd3);
    pwm = 1'b1; cyc(6);
    chk("sb_drain_d", sb.size(), 0);

    // Reset in LOW with a pending result and miss set
    ready = 1'b0;
    pwm = 1'b0; cyc(5);
    pwm = 1'b1; cyc(3); pwm = 1'b0; cyc(5);
    pwm = 1'b1; cyc(3); pwm = 1'b0; cyc(4);
    chk("pre_rst_valid", {31'd0, valid}, 1);
    chk("pre_rst_miss", {31'd0, miss}, 1);
    rst_n = 1'b0; cyc(1);
    chk("mid_rst_valid", {31'd0, valid}, 0);
    chk("mid_rst_period", {24'd0, period}, 0);
    chk("mid_rst_high", {24'd0, high}, 0);
    chk("mid_rst_miss", {31'd0, miss}, 0);
    chk("mid_rst_ovf", {31'd0, ovf}, 0);
    chk("mid_rst_level", {31'd0, level}, 0);
    chk("mid_rst_irq", {31'd0, irq}, 0);
    rst_n = 1'b1; cyc(3);
    chk("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
